// File: rtl/hes_stream_cipher_mc_pkg.sv
// Shared types and the AES forward S-box table for the multi-lane stream cipher.
package hes_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef enum logic {
    MODE_CTR = 1'b0,
    MODE_CFB = 1'b1
  } mode_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/hes_stream_cipher_mc_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module hes_sbox
  import hes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = SBOX[a_i];

endmodule

// File: rtl/hes_stream_cipher_mc.sv
// Multi-lane S-box stream cipher (CTR / byte-chained CFB) with valid/ready on both sides.
// Optional HES_MSG_STATS_EN adds saturating msg_count / drop_count outputs.
module hes_stream_cipher_mc
  import hes_pkg::*;
#(
  parameter int         LANES     = 4,
  parameter int         KEY_BYTES = 4,
  parameter logic [7:0] IV        = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic                   new_message,
  input  logic                   mode_cfb,
  input  logic                   decrypt,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [8*LANES-1:0]     data_in,
  input  logic                   last_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [8*LANES-1:0]     data_out,
  output logic                   last_out,
  output logic                   drop_err
`ifdef HES_MSG_STATS_EN
  ,
  output logic [15:0]            msg_count,
  output logic [15:0]            drop_count
`endif
);

  localparam int KSEL_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  state_e                 state_q, state_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  mode_e                  mode_q, mode_d;
  logic                   dec_q, dec_d;
  logic [15:0]            ctr_q, ctr_d;
  logic [7:0]             fb_q, fb_d;
  logic                   valid_q, valid_d;
  logic [8*LANES-1:0]     data_q, data_d;
  logic                   last_q, last_d;
  logic                   drop_q, drop_d;

  logic                   accept_s, proc_s, drop_s;
  logic [8*KEY_BYTES-1:0] key_s;
  mode_e                  mode_s;
  logic                   dec_s;
  logic [15:0]            base_ctr_s;
  logic [7:0]             base_fb_s;
  logic [8*LANES-1:0]     dout_s;
  logic [7:0]             fb_next_s;
  logic [7:0]             key_arr_s [KEY_BYTES];

  assign ready_in = !valid_q || ready_out;
  assign accept_s = valid_in && ready_in;
  assign drop_s   = accept_s && !new_message && (state_q == IDLE);
  assign proc_s   = accept_s && (new_message || (state_q == ACTIVE));

  // A new_message beat uses the live key/mode and restarts the keystream position.
  always_comb begin
    key_s      = key_q;
    mode_s     = mode_q;
    dec_s      = dec_q;
    base_ctr_s = ctr_q;
    base_fb_s  = fb_q;
    if (new_message) begin
      key_s      = key;
      mode_s     = mode_cfb ? MODE_CFB : MODE_CTR;
      dec_s      = decrypt;
      base_ctr_s = 16'h0000;
      base_fb_s  = IV;
    end else begin
      key_s      = key_q;
    end
  end

  for (genvar b = 0; b < KEY_BYTES; b++) begin : g_key
    assign key_arr_s[b] = key_s[8*b +: 8];
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [15:0]       idx_s;
    logic [KSEL_W-1:0] ksel_s;
    logic [7:0]        kbyte_s, p_s, sin_s, ks_s, din_s, dout_lane_s, ct_s;

    assign idx_s = base_ctr_s + 16'(j);

    if (KEY_BYTES > 1) begin : g_ksel
      assign ksel_s = idx_s[KSEL_W-1:0];
    end else begin : g_ksel_one
      assign ksel_s = {KSEL_W{1'b0}};
    end

    // CFB feedback chains combinationally from the previous lane's ciphertext.
    if (j == 0) begin : g_head
      assign p_s = base_fb_s;
    end else begin : g_chain
      assign p_s = g_lane[j-1].ct_s;
    end

    assign kbyte_s     = key_arr_s[ksel_s];
    assign din_s       = data_in[8*j +: 8];
    assign sin_s       = (mode_s == MODE_CFB) ? (kbyte_s ^ p_s)
                                              : (kbyte_s ^ idx_s[7:0] ^ idx_s[15:8]);
    assign dout_lane_s = din_s ^ ks_s;
    assign ct_s        = dec_s ? din_s : dout_lane_s;
    assign dout_s[8*j +: 8] = dout_lane_s;

    hes_sbox u_sbox (
      .a_i (sin_s),
      .y_o (ks_s)
    );
  end

  assign fb_next_s = g_lane[LANES-1].ct_s;

  // Message FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (proc_s && !last_in) state_d = ACTIVE;
        else                    state_d = IDLE;
      end
      ACTIVE: begin
        if (proc_s && last_in) state_d = IDLE;
        else                   state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: everything advances only on a processed beat.
  always_comb begin
    key_d   = key_q;
    mode_d  = mode_q;
    dec_d   = dec_q;
    ctr_d   = ctr_q;
    fb_d    = fb_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    drop_d  = drop_s;
    if (proc_s) begin
      key_d   = key_s;
      mode_d  = mode_s;
      dec_d   = dec_s;
      ctr_d   = base_ctr_s + 16'(LANES);
      fb_d    = fb_next_s;
      data_d  = dout_s;
      last_d  = last_in;
      valid_d = 1'b1;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      mode_q  <= MODE_CTR;
      dec_q   <= 1'b0;
      ctr_q   <= 16'h0000;
      fb_q    <= IV;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      dec_q   <= dec_d;
      ctr_q   <= ctr_d;
      fb_q    <= fb_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign last_out  = last_q;
  assign drop_err  = drop_q;

`ifdef HES_MSG_STATS_EN
  logic [15:0] msg_cnt_q, msg_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating message and drop counters.
  always_comb begin
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (proc_s && last_in && (msg_cnt_q != 16'hFFFF)) msg_cnt_d = msg_cnt_q + 16'd1;
    else                                              msg_cnt_d = msg_cnt_q;
    if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                    drop_cnt_d = drop_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_cnt_q  <= 16'h0000;
      drop_cnt_q <= 16'h0000;
    end else begin
      msg_cnt_q  <= msg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign msg_count  = msg_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/hes_stream_cipher_mc.md
Name: hes_stream_cipher_mc

Overview:
Multi-lane, parametrised successor of the single-byte AES-S-box stream cipher. It processes LANES bytes per beat with a KEY_BYTES-wide key. Two keystream modes are selected per message: CTR and byte-chained CFB. It uses valid/ready handshaking on both sides with output backpressure. It sits between the byte-stream ingress and the framing logic.

Parameters:
LANES, 4, bytes per beat (1..8)
KEY_BYTES, 4, key length in bytes; power of two, 1..16
IV, 8'h00, initial CFB feedback byte at message start

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  input beat valid
ready_in  out  1  input beat accepted when valid_in && ready_in
new_message  in  1  qualifies the first beat of a message; latches key and mode
mode_cfb  in  1  sampled with new_message; 0 = CTR, 1 = CFB
decrypt  in  1  sampled with new_message; selects CFB feedback source
key  in  8*KEY_BYTES  key; byte 0 = key[7:0]
data_in  in  8*LANES  lane 0 = data_in[7:0]
last_in  in  1  last beat of the message
valid_out  out  1  output beat valid
ready_out  in  1  downstream ready
data_out  out  8*LANES  processed bytes
last_out  out  1  last_in delayed with the data
drop_err  out  1  one-cycle pulse when a beat is discarded in IDLE

Behaviour:
- Reset: valid_out=0, data_out=0, last_out=0, drop_err=0, FSM=IDLE, ctr=0, fb=IV, key_q=0.
- Handshake:
  - ready_in = !valid_out || ready_out.
  - A beat is accepted when valid_in && ready_in.
  - Latency is exactly 1 cycle: the output register loads on accept.
  - While valid_out && !ready_out, data_out and last_out hold stable.
  - valid_out drops after a consume with no new accept.
- FSM:
  - IDLE → ACTIVE on an accepted beat with new_message=1.
  - ACTIVE → IDLE on an accepted beat with last_in=1, including a single-beat message (new_message && last_in, which stays in IDLE).
  - Accepted beat in IDLE without new_message: discarded, no output produced, drop_err pulses.
  - new_message in ACTIVE: restarts the message. Key, mode, ctr and fb reload; no error.
- Key use: on a new_message beat, the live key/mode/decrypt ports are used for that beat and latched for the rest of the message.
- Byte index: byte i of lane j uses i = ctr + j, where ctr is 16 bits. ctr=0 on a new_message beat and advances by LANES per accepted beat. ctr wraps modulo 2^16 with no flag.
- CTR keystream: k_i = SBOX[key_byte[i mod KEY_BYTES] ^ i[7:0] ^ i[15:8]].
- CFB keystream:
  - k_i = SBOX[key_byte[i mod KEY_BYTES] ^ p_i], where p_0 = IV and p_i = ciphertext byte i-1.
  - Chaining is combinational across lanes within a beat. fb registers the lane LANES-1 ciphertext for the next beat.
  - Ciphertext = data_out when decrypt=0, data_in when decrypt=1.
- Output: data_out byte = data_in byte ^ k_i. SBOX is the standard AES forward S-box.
- Stall: state (ctr, fb) advances only on accept.
- Reset mid-message: everything returns to its reset value and the pending output is lost. The next message requires new_message.

Optional Feature:
HES_MSG_STATS_EN:
- When defined, adds two outputs:
  - msg_count (16 b): messages completed, counted on accepted last_in, saturating at 16'hFFFF.
  - drop_count (16 b): saturating count of drop_err pulses.
- Both counters reset to 0.
- When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- hes_pkg holds the SBOX constant array (256×8), the state enum (IDLE, ACTIVE), and a mode enum (MODE_CTR, MODE_CFB).
- Sub-module hes_sbox: combinational byte lookup, instantiated LANES times in CTR mode and chained in CFB mode.

Test Plan:
- CTR path (LANES=1, KEY_BYTES=1, key=8'h11, new_message):
  - data 00,00 → data_out 82, CA.
  - data 53 → CA^53 = 99 on the second beat.
- CFB path (LANES=1, KEY_BYTES=1, key=8'h11, IV=00, mode_cfb=1, decrypt=0): data 00,00 → 82, DC.
- CFB round trip: the same message with decrypt=1 and data 82,DC → 00,00.
- Lane ordering (LANES=4, KEY_BYTES=1, key=00, CTR, data all zero): first beat → 63,7C,77,7B; second beat → F2,6B,6F,C5 (i=4..7).
- Backpressure: hold ready_out=0 for 3 cycles with a beat pending → data_out stable and ready_in=0. Release → the next beat continues with ctr=LANES, with no byte skipped or duplicated.
- Drop and reset:
  - A beat in IDLE without new_message → drop_err=1 for one cycle and no valid_out.
  - Reset asserted mid-message → valid_out=0 the next cycle. The next beat lacking new_message is dropped.
